// File: rtl/neural_soc_mem_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter: master index, read-tag
// entry and the legal read-latency range.
package neural_soc_mem_arb_pkg;

  typedef logic master_idx_t;

  typedef struct packed {
    logic        valid;
    master_idx_t owner;
  } rd_tag_t;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/neural_soc_onchip_memory_arbiter_if.sv
// Avalon-MM slave-port bundle for one arbiter master.
// NEURAL_SOC_MEM_ARB_LOCK_EN adds the lock signal.
interface neural_soc_onchip_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
  logic              lock;

  modport master (output address, read, write, byteenable, writedata, lock,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, byteenable, writedata, lock,
                  output waitrequest, readdata, readdatavalid);
`else
  modport master (output address, read, write, byteenable, writedata,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, byteenable, writedata,
                  output waitrequest, readdata, readdatavalid);
`endif
endinterface

// File: rtl/neural_soc_rr_arb2.sv
// Two-way round-robin grant with registered last_grant.
// NEURAL_SOC_MEM_ARB_LOCK_EN adds a lock hold that freezes the grant on its owner.
module neural_soc_rr_arb2
  import neural_soc_mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
  input  logic [1:0]  lock,
`endif
  output logic [1:0]  grant,
  output master_idx_t grant_idx
);

  master_idx_t last_grant;
  logic        any_req;
  logic        hold;

`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
  logic        locked;
  master_idx_t lock_owner;

  // Lock only holds while its owner keeps requesting; dropping req releases it.
  assign hold = locked & req[lock_owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else if (any_req) begin
      locked     <= lock[grant_idx];
      lock_owner <= grant_idx;
    end else begin
      locked     <= 1'b0;
    end
  end
`else
  assign hold = 1'b0;
`endif

  assign any_req = |req;

  always_comb begin
    grant_idx = ~last_grant;
    if (req == 2'b01)      grant_idx = 1'b0;
    else if (req == 2'b10) grant_idx = 1'b1;
`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
    if (hold)              grant_idx = lock_owner;
`endif
  end

  assign grant = any_req ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              last_grant <= 1'b1;
    else if (any_req && !hold) last_grant <= grant_idx;
  end

endmodule

// File: rtl/neural_soc_onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// NEURAL_SOC_MEM_ARB_LOCK_EN enables per-master lock inputs.
module neural_soc_onchip_memory_arbiter
  import neural_soc_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  neural_soc_onchip_memory_arbiter_if.slave m0,
  neural_soc_onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam bit LAT_OK = rd_latency_ok(RD_LATENCY);

  logic [1:0]        req;
  logic [1:0]        grant;
  master_idx_t       sel;
  logic              issue;
  logic              sel_read;
  logic              sel_write;
  rd_tag_t           tag_q [RD_LATENCY];
  rd_tag_t           ret;
  logic              rv0;
  logic              rv1;
  logic [DATA_W-1:0] hold0_q;
  logic [DATA_W-1:0] hold1_q;
  logic [1:0]        clken_sync;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  neural_soc_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
    .lock      ({m1.lock, m0.lock}),
`endif
    .grant     (grant),
    .grant_idx (sel)
  );

  assign issue          = reset_n & (|grant);
  assign m0.waitrequest = ~reset_n | (req[0] & ~grant[0]);
  assign m1.waitrequest = ~reset_n | (req[1] & ~grant[1]);

  always_comb begin
    sel_read       = sel ? m1.read      : m0.read;
    sel_write      = sel ? m1.write     : m0.write;
    mem_address    = sel ? m1.address   : m0.address;
    mem_writedata  = sel ? m1.writedata : m0.writedata;
    mem_chipselect = issue;
    mem_write      = issue & sel_write;
    mem_byteenable = mem_write ? (sel ? m1.byteenable : m0.byteenable) : '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {issue & sel_read & ~sel_write, sel};
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Read data passes straight through on the return cycle; otherwise each
  // master sees the last word it was given.
  assign ret = tag_q[RD_LATENCY-1];
  assign rv0 = ret.valid & (ret.owner == 1'b0);
  assign rv1 = ret.valid & (ret.owner == 1'b1);

  assign m0.readdatavalid = rv0;
  assign m1.readdatavalid = rv1;
  assign m0.readdata      = rv0 ? mem_readdata : hold0_q;
  assign m1.readdata      = rv1 ? mem_readdata : hold1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (rv0) hold0_q <= mem_readdata;
      if (rv1) hold1_q <= mem_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clken_sync <= '0;
    else          clken_sync <= {clken_sync[0], 1'b1};
  end

  assign mem_clken = clken_sync[1];

  a_rd_latency: assert property (@(posedge clk) LAT_OK)
    else $error("RD_LATENCY out of range");
  a_m0_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m0.read && m0.write))
    else $error("m0 read and write asserted together");
  a_m1_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m1.read && m1.write))
    else $error("m1 read and write asserted together");
  a_one_rdv: assert property (@(posedge clk) !(m0.readdatavalid && m1.readdatavalid))
    else $error("readdatavalid on both masters");

endmodule

// File: tb/tb_neural_soc_onchip_memory_arbiter.sv
// Directed bench for neural_soc_onchip_memory_arbiter with a 4x32 RAM model.
// Lock scenario is compiled in when NEURAL_SOC_MEM_ARB_LOCK_EN is defined.
module tb_neural_soc_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata = '0;
  logic [31:0] ram [4];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  neural_soc_onchip_memory_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m0_bus ();
  neural_soc_onchip_memory_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m1_bus ();

  neural_soc_onchip_memory_arbiter #(.ADDR_W(2), .DATA_W(32), .RD_LATENCY(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
    m0_bus.writedata = d; m0_bus.byteenable = be;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
    m1_bus.writedata = d; m1_bus.byteenable = be;
  endtask

  initial begin
    set_m0(1'b1, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
    m0_bus.lock = 1'b0;
    m1_bus.lock = 1'b0;
`endif
    // Reset state, with m0 requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_wait", m0_bus.waitrequest, 1);
    check("rst_m1_wait", m1_bus.waitrequest, 1);
    check("rst_m0_rdv", m0_bus.readdatavalid, 0);
    check("rst_m0_rdata", m0_bus.readdata, 0);
    check("rst_clken", mem_clken, 0);
    check("rst_cs", mem_chipselect, 0);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    reset_n = 1'b1;
    @(negedge clk);
    check("clken_early", mem_clken, 0);
    step(); step();
    @(negedge clk);
    check("clken_up", mem_clken, 1);

    // Preload addr0 / addr3 (last access by m1)
    step();
    set_m0(1'b0, 1'b1, 2'd0, 32'h11111111, 4'hF);
    @(negedge clk);
    check("pre_wr", mem_write, 1);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b0, 1'b1, 2'd3, 32'h44444444, 4'hF);
    step();

    // Both masters read continuously: grants alternate m0,m1,m0,m1
    set_m0(1'b1, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b1, 1'b0, 2'd3, '0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_m0_wait", m0_bus.waitrequest, 32'(i % 2 == 1));
      check("alt_m1_wait", m1_bus.waitrequest, 32'(i % 2 == 0));
      check("alt_addr", mem_address, (i % 2 == 0) ? 32'd0 : 32'd3);
      check("alt_m0_rdv", m0_bus.readdatavalid, 32'(i == 1 || i == 3));
      check("alt_m1_rdv", m1_bus.readdatavalid, 32'(i == 2));
      if (i == 2) check("alt_m1_data", m1_bus.readdata, 32'h44444444);
      if (i == 3) check("alt_m0_data", m0_bus.readdata, 32'h11111111);
      step();
    end
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("alt_tail_m1_rdv", m1_bus.readdatavalid, 1);
    check("alt_tail_m1_data", m1_bus.readdata, 32'h44444444);
    check("alt_tail_m0_rdv", m0_bus.readdatavalid, 0);
    check("alt_m0_hold", m0_bus.readdata, 32'h11111111);
    step();

    // Write then read back at addr2
    set_m0(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("wr_wait", m0_bus.waitrequest, 0);
    check("wr_addr", mem_address, 2);
    step();
    set_m0(1'b1, 1'b0, 2'd2, '0, 4'h0);
    @(negedge clk);
    check("rd_wait", m0_bus.waitrequest, 0);
    check("rd_memwrite", mem_write, 0);
    check("rd_be_ones", mem_byteenable, 4'hF);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("rd_rdv", m0_bus.readdatavalid, 1);
    check("rd_data", m0_bus.readdata, 32'hDEADBEEF);
    step();

    // Partial byte write, then read by m1, with an m0 write during the return
    set_m0(1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 4'hF);
    step();
    set_m0(1'b0, 1'b1, 2'd1, 32'h12345678, 4'h3);
    @(negedge clk);
    check("be_partial", mem_byteenable, 4'h3);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b1, 1'b0, 2'd1, '0, 4'hF);
    @(negedge clk);
    check("be_m1_wait", m1_bus.waitrequest, 0);
    step();
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m0(1'b0, 1'b1, 2'd2, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check("wdr_m0_wait", m0_bus.waitrequest, 0);
    check("wdr_memwrite", mem_write, 1);
    check("be_m1_rdv", m1_bus.readdatavalid, 1);
    check("be_m1_data", m1_bus.readdata, 32'hFFFF5678);
    step();

    // m0 read then m1 read back-to-back
    set_m0(1'b1, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("b2b_m0_wait", m0_bus.waitrequest, 0);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b1, 1'b0, 2'd3, '0, 4'hF);
    @(negedge clk);
    check("b2b_m1_wait", m1_bus.waitrequest, 0);
    check("b2b_m0_rdv", m0_bus.readdatavalid, 1);
    check("b2b_m0_data", m0_bus.readdata, 32'h11111111);
    check("b2b_m1_rdv0", m1_bus.readdatavalid, 0);
    step();
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("b2b_m1_rdv", m1_bus.readdatavalid, 1);
    check("b2b_m1_data", m1_bus.readdata, 32'h44444444);
    check("b2b_m0_rdv1", m0_bus.readdatavalid, 0);
    step();

    // One master streaming reads: no bubbles
    set_m0(1'b1, 1'b0, 2'd2, '0, 4'hF);
    @(negedge clk);
    check("strm_wait0", m0_bus.waitrequest, 0);
    step();
    set_m0(1'b1, 1'b0, 2'd1, '0, 4'hF);
    @(negedge clk);
    check("strm_wait1", m0_bus.waitrequest, 0);
    check("strm_data0", m0_bus.readdata, 32'hCAFEF00D);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("strm_rdv1", m0_bus.readdatavalid, 1);
    check("strm_data1", m0_bus.readdata, 32'hFFFF5678);
    step();

    // m1 read in flight when reset drops
    set_m1(1'b1, 1'b0, 2'd3, '0, 4'hF);
    @(negedge clk);
    check("inr_m1_wait", m1_bus.waitrequest, 0);
    step();
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    reset_n = 1'b0;
    @(negedge clk);
    check("inr_m1_rdv", m1_bus.readdatavalid, 0);
    check("inr_m1_rdata", m1_bus.readdata, 0);
    check("inr_m0_wait", m0_bus.waitrequest, 1);
    check("inr_clken", mem_clken, 0);
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_m1_rdv0", m1_bus.readdatavalid, 0);
    step();
    @(negedge clk);
    check("post_m1_rdv1", m1_bus.readdatavalid, 0);
    step();
    set_m0(1'b1, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b1, 1'b0, 2'd3, '0, 4'hF);
    @(negedge clk);
    check("tie1_m0_wait", m0_bus.waitrequest, 0);
    check("tie1_m1_wait", m1_bus.waitrequest, 1);
    // m0 read in flight and last_grant=m0 when reset drops again
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    reset_n = 1'b0;
    @(negedge clk);
    check("inr2_m0_rdv", m0_bus.readdatavalid, 0);
    step();
    reset_n = 1'b1;
    set_m0(1'b1, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b1, 1'b0, 2'd3, '0, 4'hF);
    @(negedge clk);
    check("tie2_m0_wait", m0_bus.waitrequest, 0);
    check("tie2_m1_wait", m1_bus.waitrequest, 1);
    step();
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    @(negedge clk);
    check("tie2_m0_rdv", m0_bus.readdatavalid, 1);
    check("tie2_m0_data", m0_bus.readdata, 32'h11111111);
    step();

`ifdef NEURAL_SOC_MEM_ARB_LOCK_EN
    // m1 locks three writes while m0 keeps requesting
    set_m0(1'b0, 1'b1, 2'd0, 32'h55555555, 4'hF);
    step();
    set_m1(1'b0, 1'b1, 2'd3, 32'h66666666, 4'hF);
    m1_bus.lock = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lock_m0_wait", m0_bus.waitrequest, 32'(c < 3));
      if (c < 3) check("lock_m1_wait", m1_bus.waitrequest, 0);
      step();
      if (c == 1) m1_bus.lock = 1'b0;
      if (c == 2) set_m1(1'b0, 1'b0, 2'd0, '0, 4'hF);
    end
    set_m0(1'b0, 1'b0, 2'd0, '0, 4'hF);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
